// File: rtl/apb_arb_defs.sv
// Shared definitions for the two-requester APB master.
package apb_arb_defs;

    // FSM encoding for the APB phase sequencer.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    localparam int          NUM_REQ     = 2;
    // Read data returned on writes and on timeout aborts.
    localparam logic [31:0] ABORT_RDATA = 32'h0;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter; the grant is combinational, the pointer
// advances only when the owner accepts a request.
module apb_rr_arbiter
    import apb_arb_defs::*;
(
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic               last_grant
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant the requester that did not win last when both ask; pointer update on advance.
    always_comb begin
        gnt          = '0;
        last_grant_d = last_grant_q;
        case (req)
            2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            default: gnt = 2'b00;
        endcase
        if (advance && (|gnt)) begin
            last_grant_d = gnt[1];
        end
    end

    // Pointer starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin accept, SETUP/ACCESS sequencing,
// bounded ACCESS wait and per-requester response routing.
module apb_master_arb
    import apb_arb_defs::*;
#(
    parameter int DEC_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        REQ_VALID0,
    input  logic        REQ_VALID1,
    output logic        REQ_READY0,
    output logic        REQ_READY1,
    input  logic [31:0] REQ_ADDR0,
    input  logic [31:0] REQ_ADDR1,
    input  logic        REQ_WRITE0,
    input  logic        REQ_WRITE1,
    input  logic [31:0] REQ_WDATA0,
    input  logic [31:0] REQ_WDATA1,
    output logic        RSP_VALID0,
    output logic        RSP_VALID1,
    output logic [31:0] RSP_RDATA0,
    output logic [31:0] RSP_RDATA1,
    output logic        RSP_ERR0,
    output logic        RSP_ERR1,
    output logic [1:0]  DECODE2BIT,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam int CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(TO_LAST);

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [31:0]              paddr_q, paddr_d;
    logic                     pwrite_q, pwrite_d;
    logic [31:0]              pwdata_q, pwdata_d;
    logic [1:0]               dec_q, dec_d;
    logic                     psel_q, psel_d;
    logic                     penable_q, penable_d;
    logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0][31:0] rsp_rdata_q, rsp_rdata_d;
    logic [NUM_REQ-1:0]       rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] gnt;
    logic               last_grant;
    logic               accept;
    logic [31:0]        sel_addr;
    logic               sel_write;
    logic [31:0]        sel_wdata;

    // last_grant doubles as the owner of the in-flight transfer: it only
    // moves on accept, so it stays put through SETUP/ACCESS.
    apb_rr_arbiter u_arb (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .req        ({REQ_VALID1, REQ_VALID0}),
        .advance    (accept),
        .gnt        (gnt),
        .last_grant (last_grant)
    );

    assign accept     = (state_q == ST_IDLE) && (|gnt);
    assign REQ_READY0 = accept & gnt[0] & ~PRESET;
    assign REQ_READY1 = accept & gnt[1] & ~PRESET;

    // Mux the fields of the requester being granted this cycle.
    always_comb begin
        sel_addr  = gnt[1] ? REQ_ADDR1  : REQ_ADDR0;
        sel_write = gnt[1] ? REQ_WRITE1 : REQ_WRITE0;
        sel_wdata = gnt[1] ? REQ_WDATA1 : REQ_WDATA0;
    end

    // Next-state and registered-output computation for the APB sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        dec_d       = dec_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    paddr_d  = sel_addr;
                    pwrite_d = sel_write;
                    pwdata_d = sel_wdata;
                    dec_d    = sel_addr[DEC_LSB +: 2];
                    cnt_d    = '0;
                    psel_d   = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d[last_grant] = 1'b1;
                    rsp_rdata_d[last_grant] = pwrite_q ? ABORT_RDATA : PRDATA;
                    rsp_err_d[last_grant]   = PSLVERR;
                    state_d                 = ST_IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    // Hung slave: give up after TIMEOUT ACCESS cycles.
                    rsp_valid_d[last_grant] = 1'b1;
                    rsp_rdata_d[last_grant] = ABORT_RDATA;
                    rsp_err_d[last_grant]   = 1'b1;
                    state_d                 = ST_IDLE;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            dec_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            dec_q       <= dec_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign PADDR      = paddr_q;
    assign PWRITE     = pwrite_q;
    assign PWDATA     = pwdata_q;
    assign DECODE2BIT = dec_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign RSP_VALID0 = rsp_valid_q[0];
    assign RSP_VALID1 = rsp_valid_q[1];
    assign RSP_RDATA0 = rsp_rdata_q[0];
    assign RSP_RDATA1 = rsp_rdata_q[1];
    assign RSP_ERR0   = rsp_err_q[0];
    assign RSP_ERR1   = rsp_err_q[1];

endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
- Two-requester APB master that front-ends the 4-port APB slave mux.
- Arbitrates round-robin between requester 0 (CPU-side) and requester 1 (DMA-side), then runs APB SETUP/ACCESS phases.
- Derives DECODE2BIT from the transfer address, waits on PREADY, and returns read data and error to the granted requester.
- Bounded wait: a per-transfer timeout aborts hung slaves.

Parameters:
- DEC_LSB, 12: LSB of the 2-bit address field driven on DECODE2BIT (PADDR[DEC_LSB+1:DEC_LSB]).
- TIMEOUT, 16: maximum ACCESS cycles per transfer; 0 disables the timeout.

Ports:
- PCLK in 1: clock, all state on rising edge.
- PRESET in 1: reset, asynchronous, active-high.
- REQ_VALID0 / REQ_VALID1 in 1: transfer request; must stay high with stable fields until accepted.
- REQ_READY0 / REQ_READY1 out 1: one-cycle accept pulse.
- REQ_ADDR0 / REQ_ADDR1 in 32: transfer address.
- REQ_WRITE0 / REQ_WRITE1 in 1: 1 = write.
- REQ_WDATA0 / REQ_WDATA1 in 32: write data.
- RSP_VALID0 / RSP_VALID1 out 1: one-cycle completion pulse.
- RSP_RDATA0 / RSP_RDATA1 out 32: read data; 0 for writes and aborts.
- RSP_ERR0 / RSP_ERR1 out 1: PSLVERR or timeout, qualified by RSP_VALIDx.
- DECODE2BIT out 2: slave select to the mux.
- PADDR out 32, PWRITE out 1, PSEL out 1, PENABLE out 1, PWDATA out 32: APB master outputs.
- PRDATA in 32, PREADY in 1, PSLVERR in 1: APB returns from the mux.

Behaviour:
- Reset: every output, the FSM and the timeout counter go to 0, with FSM in IDLE. last_grant resets to 1, so requester 0 wins the first tie. The reset is asynchronous and takes effect mid-transfer with no response issued; the APB bus drops immediately.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - If any REQ_VALIDx is high, grant per round-robin: when both are valid, grant the one != last_grant; otherwise grant the single valid one.
  - Pulse REQ_READYx combinationally in this cycle for the granted requester only.
  - Capture addr/write/wdata into PADDR/PWRITE/PWDATA and DECODE2BIT = addr[DEC_LSB+1:DEC_LSB].
  - Update last_grant, then go to SETUP.
- SETUP: PSEL=1, PENABLE=0; next state is ACCESS unconditionally.
- ACCESS:
  - PSEL=1, PENABLE=1; PREADY is sampled only here.
  - PREADY=1: next cycle RSP_VALIDx=1 for the granted requester, with RSP_RDATAx = PWRITE ? 0 : PRDATA and RSP_ERRx = PSLVERR. PSEL/PENABLE are 0 in that cycle and the FSM is in IDLE.
  - PREADY=0: the wait counter increments. If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with PREADY still 0, abort: next cycle RSP_VALIDx=1, RSP_ERRx=1, RSP_RDATAx=0, FSM returns to IDLE, and PSEL/PENABLE drop. A transfer never exceeds TIMEOUT ACCESS cycles.
  - The wait counter clears on entry to SETUP.
- Throughput: minimum 3 cycles per transfer (IDLE accept, SETUP, ACCESS). The RSP_VALID cycle coincides with the next IDLE accept cycle, so back-to-back transfers are allowed.
- PADDR/PWRITE/PWDATA/DECODE2BIT hold their last values while IDLE; they are never zeroed except by reset.
- Requests arriving in SETUP or ACCESS wait; REQ_READY stays 0.
- The block does not check whether a requester drops REQ_VALID before acceptance; that is a requester protocol violation.
- RSP_RDATA/RSP_ERR hold their values after RSP_VALID falls.
- TIMEOUT counter width is clog2(TIMEOUT+1), minimum 1 bit.

Decomposition:
- Shared package/header apb_arb_defs holds:
  - state encodings ST_IDLE=2'd0, ST_SETUP=2'd1, ST_ACCESS=2'd2;
  - NUM_REQ=2;
  - the abort read-data constant (32'h0).
- One sub-module, apb_rr_arbiter: 2-way round-robin.
  - Inputs: PCLK, PRESET, req[1:0], advance.
  - Outputs: gnt[1:0] (one-hot) and the last_grant register.
  - The top instantiates it with advance = accept-in-IDLE.

Test Plan:
- Single read: req0 addr 32'h0000_2004, slave PREADY=1 first ACCESS, PRDATA=32'hDEAD_BEEF. Expect DECODE2BIT=2'd2, REQ_READY0 at T, PSEL at T+1/T+2, PENABLE at T+2, RSP_VALID0 at T+3 with RDATA DEAD_BEEF, ERR=0.
- Write with 3 wait states: req1 write addr 32'h0000_3010, wdata 32'h1234_5678, PREADY low for 3 ACCESS cycles. Expect PWDATA stable throughout, RSP_VALID1 at T+6 with RDATA=0, ERR=0.
- Contention: both REQ_VALID high continuously for 4 transfers from reset. Expect grant order 0,1,0,1 and each REQ_READY pulse exactly once per transfer.
- Slave error: PSLVERR=1 with PREADY=1 on a read. Expect RSP_ERR0=1 and RSP_RDATA0=PRDATA.
- Timeout: TIMEOUT=4, PREADY stuck 0. Expect exactly 4 ACCESS cycles, then RSP_VALID with ERR=1, RDATA=0; PSEL falls; the next request is accepted normally.
- Reset mid-ACCESS: assert PRESET asynchronously. Expect PSEL/PENABLE/RSP_VALID=0 immediately, no response pulse after release, and requester 0 wins the next tie.
